// File: rtl/flow_ctrl_fsm.sv
// flow_ctrl_fsm: main control FSM for the NCH virtual-channel FIFO bank.
// Sequences RESET/INIT/IDLE/ACTIVE/ERROR, captures and validates the
// almost-full/almost-empty thresholds during INIT, debounces the all-empty
// condition before returning to IDLE, and latches per-channel FIFO errors.
//
// Optional feature macro: ERR_CLEAR_EN (adds err_clr, a software exit from ERROR).
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   init             request (re)configuration
//   Umbral_alto/bajo proposed almost-full / almost-empty thresholds
//   empty            per-FIFO empty flags
//   fifo_error       per-FIFO overflow/underflow pulses
//   err_clr          (ERR_CLEAR_EN only) leave ERROR for INIT
//   umbral_superior  registered almost-full threshold
//   umbral_inferior  registered almost-empty threshold
//   State            current state code
//   idle, error_out  decoded state flags
//   error_chan       sticky record of offending channels
//   cfg_bad          last INIT exit rejected (bajo > alto)
module flow_ctrl_fsm #(
    parameter int unsigned NCH       = 8,
    parameter int unsigned UW        = 3,
    parameter int unsigned IDLE_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [UW-1:0]     Umbral_alto,
    input  logic [UW-1:0]     Umbral_bajo,
    input  logic [NCH-1:0]    empty,
    input  logic [NCH-1:0]    fifo_error,
`ifdef ERR_CLEAR_EN
    input  logic              err_clr,
`endif
    output logic [UW-1:0]     umbral_superior,
    output logic [UW-1:0]     umbral_inferior,
    output logic [2:0]        State,
    output logic              idle,
    output logic              error_out,
    output logic [NCH-1:0]    error_chan,
    output logic              cfg_bad
);

    localparam int unsigned HCW = $clog2(IDLE_HOLD + 1);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [HCW-1:0]     hc, hc_nxt;
    logic [UW-1:0]      sup_nxt, inf_nxt;
    logic [NCH-1:0]     chan_nxt;
    logic               cfg_bad_nxt;
    logic               any_err;
    logic               all_empty;

    assign any_err   = |fifo_error;
    assign all_empty = &empty;
    assign State     = state;

    // State and all output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_RESET;
            hc              <= '0;
            umbral_superior <= '0;
            umbral_inferior <= '0;
            idle            <= 1'b0;
            error_out       <= 1'b0;
            error_chan      <= '0;
            cfg_bad         <= 1'b0;
        end else begin
            state           <= state_nxt;
            hc              <= hc_nxt;
            umbral_superior <= sup_nxt;
            umbral_inferior <= inf_nxt;
            idle            <= (state_nxt == ST_IDLE);
            error_out       <= (state_nxt == ST_ERROR);
            error_chan      <= chan_nxt;
            cfg_bad         <= cfg_bad_nxt;
        end
    end

    // Next-state and next-output logic; priority fifo_error > init > state rule
    always_comb begin
        state_nxt   = state;
        hc_nxt      = '0;
        sup_nxt     = umbral_superior;
        inf_nxt     = umbral_inferior;
        chan_nxt    = error_chan;
        cfg_bad_nxt = cfg_bad;

        case (state)
            ST_RESET: begin
                state_nxt = ST_INIT;
            end

            ST_INIT: begin
                // Transparent capture: thresholds follow the inputs while in INIT
                sup_nxt = Umbral_alto;
                inf_nxt = Umbral_bajo;
                if (any_err) begin
                    state_nxt = ST_ERROR;
                    chan_nxt  = error_chan | fifo_error;
                end else if (init) begin
                    state_nxt = ST_INIT;
                end else if (Umbral_bajo <= Umbral_alto) begin
                    state_nxt   = ST_IDLE;
                    cfg_bad_nxt = 1'b0;
                end else begin
                    state_nxt   = ST_ERROR;
                    cfg_bad_nxt = 1'b1;
                end
            end

            ST_IDLE: begin
                if (any_err) begin
                    state_nxt = ST_ERROR;
                    chan_nxt  = error_chan | fifo_error;
                end else if (init) begin
                    state_nxt = ST_INIT;
                end else if (!all_empty) begin
                    state_nxt = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                if (any_err) begin
                    state_nxt = ST_ERROR;
                    chan_nxt  = error_chan | fifo_error;
                end else if (init) begin
                    state_nxt = ST_INIT;
                end else if (all_empty) begin
                    // Leave on the sample that would bring hc to IDLE_HOLD
                    if (hc >= HCW'(IDLE_HOLD - 1)) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        hc_nxt = hc + HCW'(1);
                    end
                end
            end

            ST_ERROR: begin
                chan_nxt = error_chan | fifo_error;
`ifdef ERR_CLEAR_EN
                if (err_clr && !any_err) begin
                    state_nxt   = ST_INIT;
                    chan_nxt    = '0;
                    cfg_bad_nxt = 1'b0;
                end
`endif
            end

            default: begin
                state_nxt = ST_RESET;
            end
        endcase
    end

endmodule

// File: doc/flow_ctrl_fsm.md
Name: flow_ctrl_fsm

Overview:
Parametrised successor to the transaction-layer main control state machine. It sequences RESET/INIT/IDLE/ACTIVE/ERROR for NCH virtual-channel FIFOs and captures the almost-full/almost-empty thresholds during INIT. It also validates those thresholds, debounces the all-empty condition before returning to IDLE, and latches per-channel FIFO errors. It sits between the host config inputs and the FIFO bank, and drives the threshold buses and status to the FIFOs and the arbiter.

Parameters:
NCH, 8, number of channels (FIFOs), 1..32
UW, 3, threshold width in bits
IDLE_HOLD, 4, consecutive all-empty cycles required in ACTIVE before returning to IDLE, 1..255

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
init  in  1  request (re)configuration
Umbral_alto  in  UW  proposed almost-full threshold
Umbral_bajo  in  UW  proposed almost-empty threshold
empty  in  NCH  per-FIFO empty flags
fifo_error  in  NCH  per-FIFO overflow/underflow pulses
umbral_superior  out  UW  registered almost-full threshold to FIFOs
umbral_inferior  out  UW  registered almost-empty threshold to FIFOs
State  out  3  current state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4
idle  out  1  high iff State==IDLE
error_out  out  1  high iff State==ERROR
error_chan  out  NCH  sticky record of channels that caused ERROR
cfg_bad  out  1  last INIT exit was rejected because Umbral_bajo > Umbral_alto

Behaviour:
- All outputs are registered. At reset=1, on the next edge: State=RESET and all other outputs 0. Reset has top priority in every state, including mid-operation.
- Transition priority when reset=0: any fifo_error bit > init > state-specific rule.
- RESET: go to INIT unconditionally on the next edge.
- INIT: each cycle, umbral_superior<=Umbral_alto and umbral_inferior<=Umbral_bajo (transparent capture).
  - Stay while init=1.
  - When init=0 and Umbral_bajo<=Umbral_alto (unsigned): go to IDLE and set cfg_bad=0.
  - When init=0 and Umbral_bajo>Umbral_alto: go to ERROR and set cfg_bad=1. error_chan is unchanged.
- Thresholds hold their values in every state except INIT.
- IDLE:
  - init=1: go to INIT.
  - any empty bit = 0: go to ACTIVE.
  - otherwise stay.
- ACTIVE:
  - Hold counter hc, width clog2(IDLE_HOLD+1).
  - hc increments (saturating at IDLE_HOLD) each cycle that empty is all 1s, and resets to 0 on any 0 bit.
  - When the all-1s sample would bring hc to IDLE_HOLD, go to IDLE on that edge. With IDLE_HOLD=1, one all-empty cycle returns to IDLE on the next edge.
  - hc is cleared on ACTIVE entry.
  - init=1: go to INIT.
- Any state except RESET and ERROR: fifo_error!=0 sends the FSM to ERROR, and error_chan |= fifo_error on the same edge.
- ERROR: remain here. error_chan keeps accumulating any further fifo_error bits. Exit is only via reset, or via the optional clear described below.
- idle and error_out are decoded from the next-state register, so they are valid in the same cycle as State.
- Simultaneous init=1 and fifo_error: ERROR wins.
- Simultaneous reset and anything else: RESET wins.
- Latency from any input to its effect on the outputs: 1 clock.

Optional Feature:
ERR_CLEAR_EN. When defined:
- Adds input port err_clr (1 bit).
- In ERROR with err_clr=1 and fifo_error==0: go to INIT on the next edge and clear error_chan and cfg_bad.
- err_clr is ignored in all other states.

When undefined:
- There is no err_clr port.
- ERROR is left only by reset.
- Behaviour is otherwise identical.

Test Plan:
- Reset/init capture (NCH=8, UW=3): assert reset 2 cycles, then init=1 with Umbral_alto=6 and Umbral_bajo=1 → State 0 then 1; umbral_superior=6 and umbral_inferior=1 one cycle after capture; after init=0 → State=2, idle=1, cfg_bad=0.
- Bad config: init=1→0 with Umbral_alto=2, Umbral_bajo=5 → State=4, error_out=1, cfg_bad=1, error_chan=0; thresholds read 2 and 5 (last INIT values).
- Debounce (IDLE_HOLD=4): from IDLE, empty=8'hFB → ACTIVE. Then all-1s for 3 cycles, one 8'hFE cycle, then all-1s → State stays 3 until the 4th consecutive all-1s sample, then 2 on the following edge.
- Errors: in ACTIVE, drive fifo_error=8'h04 for 1 cycle, then 8'h80 in ERROR → State=4, then error_chan=8'h04, then 8'h84. A later init=1 leaves State=4.
- Priority/reset mid-op: in ACTIVE, drive init=1 and fifo_error=8'h01 together → ERROR. Then assert reset for 1 cycle → State=0, error_chan=0, umbral_*=0, then INIT.
- With ERR_CLEAR_EN: in ERROR, err_clr=1 → State=1 next edge with error_chan=0 and cfg_bad=0. With err_clr=1 and fifo_error=8'h02 together → stays ERROR and error_chan gains bit 1.
